uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the 8-bit UART receiver (rxDone/rxErr/out).
//  Captures each completed, error-free byte into a DEPTH-entry circular FIFO.
//  Presents a first-word-fall-through read port to the host logic, so the consumer can drain in bursts.
//  Tracks overflow and framing-error events with sticky flags and a saturating error counter.
// PARAMETERS
//  DEPTH_LOG2   4    log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries (16)
//  ERR_CNT_W    8    width of saturating framing-error counter
// PORTS
//  clk          in   1           system clock, same domain as the UART receiver
//  reset        in   1           synchronous, active-high reset
//  rxDone       in   1           receiver done level; may stay high for many clk cycles
//  rxErr        in   1           receiver framing/start-glitch error, sampled with rxDone edge
//  rxByte       in   8           receiver data (receiver `out`), stable while rxDone high
//  rdEn         in   1           pop head entry this cycle (ignored when empty)
//  rdData       out  8           head entry; valid whenever empty==0
//  empty        out  1           no entries
//  full         out  1           DEPTH entries
//  count        out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
//  overflow     out  1           sticky: a byte was dropped because FIFO was full
//  errCount     out  ERR_CNT_W   saturating count of rxDone events with rxErr=1
//  clearFlags   in   1           clears overflow and errCount (reset-equivalent for them)
// BEHAVIOUR
//  - Reset: wrPtr=rdPtr=0, count=0, empty=1, full=0, overflow=0, errCount=0, rdData=8'h00, rxDone history=0.
//  - Capture: push event = rxDone rising edge (rxDone & ~rxDonePrev, registered prev). Held level pushes once.
//  - Event with rxErr=0: push rxByte. Event with rxErr=1: no push, errCount+=1 (saturates at all-ones).
//  - Write latency: byte pushed on edge cycle N is visible on rdData, empty=0 at cycle N+1.
//  - Read: FWFT; rdData=mem[rdPtr]; rdEn & ~empty advances rdPtr at the clock edge; next head visible N+1.
//  - rdEn while empty: no effect, no underflow flag, pointers unchanged.
//  - Full + push, no pop: byte dropped, overflow<=1, contents/pointers unchanged.
//  - Full + push + pop same cycle: both succeed; count stays DEPTH; overflow not set.
//  - Empty + push + pop same cycle: pop ignored (nothing to pop); push succeeds; count=1.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH; count tracked separately (DEPTH_LOG2+1 bits).
//  - full = (count==DEPTH), empty = (count==0); both registered-derived, no combinational input paths.
//  - clearFlags same cycle as a new overflow/error event: the event wins (flag set / counter=1).
//  - Reset mid-operation: all entries discarded immediately; a rxDone still high after reset
//    does not push (prev history forced to 0 only if rxDone low; prev<=rxDone during reset so no edge).
// CONFIGURATION
//  UART_RX_FIFO_ERR_TAG_EN defined: errored bytes are also pushed, each entry widened to 9 bits
//    {err,byte}; extra output rdErr (1 bit) accompanies rdData; errCount still increments.
//  Undefined: entries are 8 bits, errored bytes dropped, no rdErr port.
// STRUCTURE
//  - Shared uart_pkg: UART_DATA_W=8 constant, FIFO entry width constant (8 or 9 per macro).
//  - One sub-module uart_rx_fifo_mem: DEPTH x width register file, 1 sync write port, async read port.
//  - Top holds edge detect, pointers, count, flags, counter.
// TESTING
//  1 Reset, then rxDone pulse with rxByte=8'h35, rxErr=0 held 60 cycles -> exactly one entry; next cycle rdData=8'h35, count=1.
//  2 Push 16 bytes 8'h00..8'h0F, then 17th 8'hFF -> full=1, overflow=1; drain yields 00..0F in order, then empty=1.
//  3 Full FIFO, push 8'hA5 with rdEn same cycle -> count stays 16, overflow=0, last pop after drain returns 8'hA5.
//  4 Three rxDone events with rxErr=1 (glitched start bit) -> errCount=3, count=0; clearFlags -> errCount=0.
//  5 Fill 5 entries, assert reset for 1 cycle with rxDone still high -> empty=1, count=0, no push after reset release.
//  6 Wrap: push/pop 40 bytes keeping count<=3 -> data order intact across pointer wrap; with ERR_TAG_EN, errored byte read back with rdErr=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : uart_pkg
//  Purpose   : Shared UART receive-path constants (data and FIFO entry width).
//  Revision  : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    // Each entry carries the receiver error bit above the data byte.
    localparam int FIFO_ENTRY_W = UART_DATA_W + 1;
`else
    localparam int FIFO_ENTRY_W = UART_DATA_W;
`endif

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module    : uart_rx_fifo_mem
//  Purpose   : 2**ADDR_W x DATA_W register file, one sync write, one async read.
//  Revision  : 1.0  initial release
// ============================================================================
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = FIFO_ENTRY_W
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : uart_rx_fifo
//  Purpose   : FWFT byte FIFO behind the UART receiver with overflow flag and
//              saturating framing-error counter. Macro UART_RX_FIFO_ERR_TAG_EN
//              also stores errored bytes, tagged, and adds the rdErr output.
//  Revision  : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rxDone,
    input  logic                   rxErr,
    input  logic [UART_DATA_W-1:0] rxByte,
    input  logic                   rdEn,
    input  logic                   clearFlags,
    output logic [UART_DATA_W-1:0] rdData,
`ifdef UART_RX_FIFO_ERR_TAG_EN
    output logic                   rdErr,
`endif
    output logic                   empty,
    output logic                   full,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   errCount
);

    localparam logic [DEPTH_LOG2:0] c_DEPTH = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    logic                    r_rxDonePrev;
    logic [DEPTH_LOG2-1:0]   r_wrPtr;
    logic [DEPTH_LOG2-1:0]   r_rdPtr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_overflow;
    logic [ERR_CNT_W-1:0]    r_errCount;

    logic                    w_event;
    logic                    w_push;
    logic                    w_errEvt;
    logic                    w_pop;
    logic                    w_wrOk;
    logic                    w_full;
    logic                    w_empty;
    logic [FIFO_ENTRY_W-1:0] w_wrData;
    logic [FIFO_ENTRY_W-1:0] w_rdEntry;

    assign w_event  = rxDone & ~r_rxDonePrev;
    assign w_errEvt = w_event & rxErr;
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign w_push   = w_event;
    assign w_wrData = {rxErr, rxByte};
`else
    assign w_push   = w_event & ~rxErr;
    assign w_wrData = rxByte;
`endif

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_pop  = rdEn & ~w_empty;
    assign w_wrOk = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        // Tracking rxDone through reset keeps a held level from pushing afterwards.
        r_rxDonePrev <= rxDone;
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_errCount <= '0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + DEPTH_LOG2'(1);
            end
            case ({w_wrOk, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase

            // New events take priority over a same-cycle clear.
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end else if (clearFlags) begin
                r_overflow <= 1'b0;
            end

            if (w_errEvt) begin
                if (clearFlags) begin
                    r_errCount <= ERR_CNT_W'(1);
                end else if (r_errCount != '1) begin
                    r_errCount <= r_errCount + ERR_CNT_W'(1);
                end
            end else if (clearFlags) begin
                r_errCount <= '0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (FIFO_ENTRY_W)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_wrOk),
        .i_wrAddr (r_wrPtr),
        .i_wrData (w_wrData),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdEntry)
    );

    // Masking with empty gives a defined zero head without resetting storage.
    assign rdData   = w_empty ? '0 : w_rdEntry[UART_DATA_W-1:0];
`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign rdErr    = ~w_empty & w_rdEntry[UART_DATA_W];
`endif
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign errCount = r_errCount;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : tb_uart_rx_fifo
//  Purpose   : Directed self-checking bench for uart_rx_fifo.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxDone = 1'b0;
    logic       rxErr = 1'b0;
    logic [7:0] rxByte = 8'h00;
    logic       rdEn = 1'b0;
    logic       clearFlags = 1'b0;
    logic [7:0] rdData;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] errCount;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic       rdErr;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxDone     (rxDone),
        .rxErr      (rxErr),
        .rxByte     (rxByte),
        .rdEn       (rdEn),
        .clearFlags (clearFlags),
        .rdData     (rdData),
`ifdef UART_RX_FIFO_ERR_TAG_EN
        .rdErr      (rdErr),
`endif
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .errCount   (errCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushByte(input logic [7:0] b, input logic err);
        rxByte = b; rxErr = err; rxDone = 1'b1;
        tick();
        rxDone = 1'b0; rxErr = 1'b0;
        tick();
    endtask

    task automatic popCheck(input logic [7:0] exp, input string name);
        vectors++;
        if (rdData !== exp) begin
            miscompares++;
            $display("FAIL %s: rdData got %h expected %h", name, rdData, exp);
        end
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({empty, full, count, overflow, errCount, rdData} !== {1'b1, 1'b0, 5'd0, 1'b0, 8'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: got e=%b f=%b c=%0d o=%b ec=%0d d=%h expected e=1 f=0 c=0 o=0 ec=0 d=00",
                     empty, full, count, overflow, errCount, rdData);
        end
    endtask

    task automatic test_single_push();
        rxByte = 8'h35; rxErr = 1'b0; rxDone = 1'b1;
        tick();
        vectors++;
        if (count !== 5'd1 || rdData !== 8'h35 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL push_latency: got c=%0d d=%h e=%b expected c=1 d=35 e=0", count, rdData, empty);
        end
        repeat (59) tick();
        rxDone = 1'b0;
        tick();
        vectors++;
        if (count !== 5'd1 || rdData !== 8'h35) begin
            miscompares++;
            $display("FAIL held_level_once: got c=%0d d=%h expected c=1 d=35", count, rdData);
        end
        popCheck(8'h35, "single_pop");
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_drain: got e=%b c=%0d expected e=1 c=0", empty, count);
        end
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || rdData !== 8'h00) begin
            miscompares++;
            $display("FAIL underflow_ignored: got e=%b c=%0d d=%h expected e=1 c=0 d=00", empty, count, rdData);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) pushByte(8'(i), 1'b0);
        vectors++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_16: got f=%b c=%0d o=%b expected f=1 c=16 o=0", full, count, overflow);
        end
        pushByte(8'hFF, 1'b0);
        vectors++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got f=%b c=%0d o=%b expected f=1 c=16 o=1", full, count, overflow);
        end
        for (int i = 0; i < 16; i++) popCheck(8'(i), "overflow_drain");
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_empty: got e=%b c=%0d o=%b expected e=1 c=0 o=1", empty, count, overflow);
        end
        clearFlags = 1'b1;
        tick();
        clearFlags = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got o=%b expected o=0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) pushByte(8'(8'h10 + i), 1'b0);
        rxByte = 8'hA5; rxDone = 1'b1; rdEn = 1'b1;
        tick();
        rxDone = 1'b0; rdEn = 1'b0;
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || rdData !== 8'h11) begin
            miscompares++;
            $display("FAIL full_push_pop: got c=%0d o=%b f=%b d=%h expected c=16 o=0 f=1 d=11",
                     count, overflow, full, rdData);
        end
        tick();
        for (int i = 1; i < 16; i++) popCheck(8'(8'h10 + i), "full_pp_drain");
        popCheck(8'hA5, "full_pp_last");
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pp_empty: got e=%b expected e=1", empty);
        end
    endtask

    task automatic test_err_events();
        for (int i = 0; i < 3; i++) pushByte(8'h5A, 1'b1);
`ifdef UART_RX_FIFO_ERR_TAG_EN
        vectors++;
        if (errCount !== 8'd3 || count !== 5'd3 || rdErr !== 1'b1) begin
            miscompares++;
            $display("FAIL err_events: got ec=%0d c=%0d re=%b expected ec=3 c=3 re=1", errCount, count, rdErr);
        end
        for (int i = 0; i < 3; i++) popCheck(8'h5A, "err_tag_drain");
`else
        vectors++;
        if (errCount !== 8'd3 || count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL err_events: got ec=%0d c=%0d e=%b expected ec=3 c=0 e=1", errCount, count, empty);
        end
`endif
        clearFlags = 1'b1;
        tick();
        clearFlags = 1'b0;
        vectors++;
        if (errCount !== 8'd0) begin
            miscompares++;
            $display("FAIL err_clear: got ec=%0d expected 0", errCount);
        end
        pushByte(8'h01, 1'b1);
        pushByte(8'h02, 1'b1);
        rxByte = 8'h03; rxErr = 1'b1; rxDone = 1'b1; clearFlags = 1'b1;
        tick();
        rxDone = 1'b0; rxErr = 1'b0; clearFlags = 1'b0;
        tick();
        vectors++;
        if (errCount !== 8'd1) begin
            miscompares++;
            $display("FAIL err_clear_race: got ec=%0d expected 1", errCount);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        rxByte = 8'hC3; rxErr = 1'b0; rxDone = 1'b1; rdEn = 1'b1;
        tick();
        rxDone = 1'b0; rdEn = 1'b0;
        vectors++;
        if (count !== 5'd1 || rdData !== 8'hC3) begin
            miscompares++;
            $display("FAIL empty_push_pop: got c=%0d d=%h expected c=1 d=C3", count, rdData);
        end
        tick();
        popCheck(8'hC3, "empty_pp_pop");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) pushByte(8'(8'h40 + i), 1'b0);
        rxByte = 8'h77; rxDone = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || rdData !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: got e=%b c=%0d d=%h expected e=1 c=0 d=00", empty, count, rdData);
        end
        rxDone = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] b;
        for (int i = 0; i < 40; i++) begin
            b = 8'(i * 7 + 3);
            pushByte(b, 1'b0);
            q.push_back(b);
            if (q.size() == 3) popCheck(q.pop_front(), "wrap_order");
            vectors++;
            if (count !== 5'(q.size())) begin
                miscompares++;
                $display("FAIL wrap_count: got %0d expected %0d", count, q.size());
            end
        end
        while (q.size() > 0) popCheck(q.pop_front(), "wrap_drain");
`ifdef UART_RX_FIFO_ERR_TAG_EN
        pushByte(8'h9E, 1'b1);
        vectors++;
        if (rdErr !== 1'b1 || rdData !== 8'h9E) begin
            miscompares++;
            $display("FAIL wrap_err_tag: got re=%b d=%h expected re=1 d=9E", rdErr, rdData);
        end
        popCheck(8'h9E, "wrap_err_pop");
`endif
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_empty: got e=%b expected e=1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_overflow();
        test_full_push_pop();
        test_err_events();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
